cache: RTL and testbench

- Direct-mapped, write-through, write-allocate byte cache between a CPU and a 16-bit-address backing memory.
- Line = 2-byte block (bytes at even address A and A+1).
- Every write goes to memory. Read hits are served locally. Read misses fetch the block.
- An invalidate port drops a cached block when the memory side reports external modification.

---
 rtl/cache.sv | 120 ++++++++++++
 tb/tb_cache.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache.sv
// Direct-mapped, write-through, write-allocate byte cache with 2-byte lines.
// Read hits complete locally; writes and read misses go to memory and refill the line.
module cache #(
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [24:0] cpu_request,
   input  logic        cpu_request_ready,
   input  logic [15:0] invalidate_address,
   input  logic [15:0] memory_response,
   input  logic        memory_response_ready,
   output logic [24:0] memory_request,
   output logic        memory_request_ready,
   output logic [7:0]  data_out,
   output logic        data_out_ready
);

   localparam int unsigned NUM_LINES = 2 ** INDEX_BITS;
   localparam int unsigned TAG_BITS  = 15 - INDEX_BITS;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOOKUP = 2'd1;
   localparam logic [1:0] MEM    = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]           state;
   logic [24:0]          req;
   logic [15:0]          inv_reg;
   logic [NUM_LINES-1:0] line_valid;
   logic [TAG_BITS-1:0]  line_tag  [NUM_LINES];
   logic [15:0]          line_data [NUM_LINES];

   logic                  req_write;
   logic [15:0]           req_addr;
   logic [INDEX_BITS-1:0] req_index;
   logic [TAG_BITS-1:0]   req_tag;
   logic                  hit;
   logic                  fill;
   logic [INDEX_BITS-1:0] inv_index;
   logic [TAG_BITS-1:0]   inv_tag;
   logic                  inv_hit;

   assign req_write = req[24];
   assign req_addr  = req[15:0];
   assign req_index = req_addr[INDEX_BITS:1];
   assign req_tag   = req_addr[15:INDEX_BITS+1];
   assign hit       = line_valid[req_index] && (line_tag[req_index] == req_tag);
   assign fill      = (state == MEM) && memory_response_ready;

   assign inv_index = invalidate_address[INDEX_BITS:1];
   assign inv_tag   = invalidate_address[15:INDEX_BITS+1];

   // A fill landing on the same line this cycle is judged by the incoming tag,
   // so an invalidation of the block being fetched still leaves the line invalid.
   always_comb begin
      inv_hit = 1'b0;
      if (invalidate_address != inv_reg) begin
         if (fill && (inv_index == req_index))
            inv_hit = (inv_tag == req_tag);
         else
            inv_hit = line_valid[inv_index] && (line_tag[inv_index] == inv_tag);
      end
   end

   assign memory_request       = req;
   assign memory_request_ready = (state == MEM);
   assign data_out_ready       = (state == DONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         req        <= '0;
         inv_reg    <= '0;
         line_valid <= '0;
         data_out   <= '0;
      end else begin
         inv_reg <= invalidate_address;
         case (state)
            IDLE: begin
               if (cpu_request_ready) begin
                  req   <= cpu_request;
                  state <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (!req_write && hit) begin
                  data_out <= req_addr[0] ? line_data[req_index][15:8]
                                          : line_data[req_index][7:0];
                  state    <= DONE;
               end else begin
                  state <= MEM;
               end
            end
            MEM: begin
               if (memory_response_ready) begin
                  line_valid[req_index] <= 1'b1;
                  data_out <= req_addr[0] ? memory_response[15:8] : memory_response[7:0];
                  state    <= DONE;
               end
            end
            DONE: begin
               if (!cpu_request_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (inv_hit)
            line_valid[inv_index] <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && fill) begin
         line_tag[req_index]  <= req_tag;
         line_data[req_index] <= memory_response;
      end
   end

endmodule

// File: tb/tb_cache.sv
// Randomized scoreboard bench for the byte cache: a flat memory image plus a
// block-per-line residency table predict data and hit/miss for each request.
module tb_cache;

   localparam int unsigned IB = 6;
   localparam int NL = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [24:0] cpu_request = '0;
   logic        cpu_request_ready = 1'b0;
   logic [15:0] invalidate_address = '0;
   logic [15:0] memory_response = '0;
   logic        memory_response_ready = 1'b0;
   logic [24:0] memory_request;
   logic        memory_request_ready;
   logic [7:0]  data_out;
   logic        data_out_ready;

   always #5 clock = ~clock;

   cache #(.INDEX_BITS(IB)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .cpu_request           (cpu_request),
      .cpu_request_ready     (cpu_request_ready),
      .invalidate_address    (invalidate_address),
      .memory_response       (memory_response),
      .memory_response_ready (memory_response_ready),
      .memory_request        (memory_request),
      .memory_request_ready  (memory_request_ready),
      .data_out              (data_out),
      .data_out_ready        (data_out_ready)
   );

   typedef struct {
      logic [24:0] req;
      logic [7:0]  data;
      bit          miss;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mem [65536];
   int         line_blk [NL];
   int         tests = 0;
   int         fails = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
      end
   endfunction

   function automatic int line_of(input logic [15:0] a);
      return (int'(a) / 2) % NL;
   endfunction

   task automatic reset_dut();
      reset = 1'b1;
      cpu_request_ready = 1'b0;
      memory_response_ready = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      foreach (line_blk[i]) line_blk[i] = -1;
      exp_q.delete();
      @(negedge clock);
   endtask

   task automatic change_inv(input logic [15:0] a);
      if (invalidate_address == a) invalidate_address = a ^ 16'd1;
      else invalidate_address = a;
   endtask

   // Memory changed behind the cache's back, announced on the invalidate port.
   task automatic external_write(input logic [15:0] a, input bit modify);
      if (modify) mem[a] = 8'($urandom);
      change_inv(a);
      if (line_blk[line_of(a)] == int'(a) / 2) line_blk[line_of(a)] = -1;
      @(negedge clock);
   endtask

   task automatic access(input bit wr, input logic [7:0] wd, input logic [15:0] a, input bit inv_on_fill);
      exp_t e;
      int   idx;
      int   blk;
      int   delay;
      bit   responded;
      idx = line_of(a);
      blk = int'(a) / 2;
      responded = 1'b0;
      e.req  = {wr, wd, a};
      e.miss = wr || (line_blk[idx] != blk);
      e.data = wr ? wd : mem[a];
      exp_q.push_back(e);
      line_blk[idx] = blk;
      if (e.miss && inv_on_fill) line_blk[idx] = -1;
      cpu_request = e.req;
      cpu_request_ready = 1'b1;
      delay = $urandom_range(0, 3);
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         memory_response_ready = 1'b0;
         if (data_out_ready) break;
         if (memory_request_ready && !responded) begin
            if (delay == 0) begin
               if (wr) mem[a] = wd;
               memory_response = {mem[a | 16'd1], mem[a & 16'hFFFE]};
               memory_response_ready = 1'b1;
               responded = 1'b1;
               if (inv_on_fill) change_inv(a);
            end else begin
               delay--;
            end
         end
      end
      cpu_request_ready = 1'b0;
      memory_response_ready = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   // Monitor: checks each completion against the head of the expectation queue.
   initial begin
      exp_t e;
      int   wd_cnt;
      bit   done_seen;
      bit   saw_mem;
      bit   prev_mrr;
      wd_cnt = 0;
      done_seen = 1'b0;
      saw_mem = 1'b0;
      prev_mrr = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_memory_request", 32'(memory_request), 32'd0);
      chk("rst_memory_request_ready", 32'(memory_request_ready), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_data_out_ready", 32'(data_out_ready), 32'd0);
      forever begin
         @(negedge clock);
         if (memory_request_ready && !prev_mrr) begin
            saw_mem = 1'b1;
            if (exp_q.size() > 0) chk("memory_request", 32'(memory_request), 32'(exp_q[0].req));
         end
         prev_mrr = memory_request_ready;
         if (cpu_request_ready && !data_out_ready) wd_cnt++;
         else wd_cnt = 0;
         if (wd_cnt == 64) chk("done_within_64_cycles", 32'(data_out_ready), 32'd1);
         if (data_out_ready && !done_seen) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
               chk("unexpected_completion", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("data_out", 32'(data_out), 32'(e.data));
               chk("went_to_memory", 32'(saw_mem), 32'(e.miss));
               chk("ready_exclusive", 32'(memory_request_ready), 32'd0);
            end
            saw_mem = 1'b0;
         end
         if (!data_out_ready) done_seen = 1'b0;
      end
   end

   initial begin
      logic [15:0] a;
      int          r;
      foreach (mem[i]) mem[i] = 8'($urandom);
      reset_dut();

      access(1'b1, 8'd55, 16'd12, 1'b0);
      access(1'b0, 8'd0, 16'd12, 1'b0);
      access(1'b1, 8'd56, 16'd13, 1'b0);
      access(1'b0, 8'd0, 16'd12, 1'b0);
      access(1'b0, 8'd0, 16'd13, 1'b0);
      access(1'b1, 8'd34, 16'd14, 1'b0);
      access(1'b1, 8'd127, 16'd15, 1'b0);
      access(1'b0, 8'd0, 16'd14, 1'b0);
      access(1'b0, 8'd0, 16'd13, 1'b0);
      access(1'b0, 8'd0, 16'd15, 1'b0);
      access(1'b0, 8'd0, 16'd12, 1'b0);
      access(1'b1, 8'd137, 16'd12, 1'b0);
      access(1'b0, 8'd0, 16'd12, 1'b0);

      access(1'b1, 8'd21, 16'd0, 1'b0);
      access(1'b1, 8'd23, 16'd1, 1'b0);
      access(1'b0, 8'd0, 16'd0, 1'b0);
      access(1'b0, 8'd0, 16'd1, 1'b0);
      access(1'b1, 8'd33, 16'd65534, 1'b0);
      access(1'b1, 8'd34, 16'd65535, 1'b0);
      access(1'b0, 8'd0, 16'd65534, 1'b0);
      access(1'b0, 8'd0, 16'd65535, 1'b0);

      // Same index, different tag: the two blocks evict each other.
      access(1'b0, 8'd0, 16'd12, 1'b0);
      access(1'b0, 8'd0, 16'd140, 1'b0);
      access(1'b0, 8'd0, 16'd12, 1'b0);

      access(1'b1, 8'd15, 16'd16, 1'b0);
      external_write(16'd16, 1'b0);
      access(1'b0, 8'd0, 16'd16, 1'b0);

      // Invalidation coinciding with the refill of the same block.
      access(1'b0, 8'd0, 16'd200, 1'b1);
      access(1'b0, 8'd0, 16'd200, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 9) == 0) a = 16'($urandom);
         else a = 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
         r = $urandom_range(0, 99);
         if (r < 45)      access(1'b0, 8'd0, a, 1'b0);
         else if (r < 80) access(1'b1, 8'($urandom), a, 1'b0);
         else if (r < 90) external_write(a, 1'b1);
         else             access(1'($urandom_range(0, 1)), 8'($urandom), a, 1'b1);
      end

      reset_dut();
      for (int i = 0; i < 512; i++) access(1'b0, 8'd0, 16'(i), 1'b0);

      repeat (5) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
